// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   lsu_state_t   : IDLE / REQ / DONE bus sequencing states
//   F3_*          : RV32 load/store funct3 size/sign encodings
//   is_misaligned : flags an access that must not reach the bus, either
//                   because it is misaligned or because funct3 is illegal
//                   for that direction (stores have no unsigned variants)
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo,
                                         input logic       is_store);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = is_store;
      F3_H:    bad = addr_lo[0];
      F3_HU:   bad = is_store | addr_lo[0];
      F3_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
//   funct3    in  : access size/sign
//   byte_off  in  : address bits [1:0]
//   rdata     in  : raw bus read word
//   sd        in  : raw store operand (rs2)
//   load_data out : extracted and sign/zero-extended load result
//   wstrb     out : byte strobes for a store
//   wdata     out : store operand replicated across all lanes
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  input  logic [31:0] sd,
  output logic [31:0] load_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata
);

  logic [31:0] shifted;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    shifted  = rdata >> {byte_off, 3'b000};
    sel_byte = shifted[7:0];
    sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = rdata;
    endcase

    // Only the size bits matter for stores; illegal encodings never reach the bus.
    case (funct3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << byte_off;
        wdata = {4{sd[7:0]}};
      end
      2'b01: begin
        wstrb = 4'b0011 << byte_off;
        wdata = {2{sd[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = sd;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: turns one load/store into a single req/ack
// data-bus transaction, stalls the pipeline while it is outstanding and
// presents the formatted load result in the DONE cycle.
//   clk, reset (async, active low)
//   mem_rd/mem_wr/funct3/mem_addr/store_data : EX/MEM instruction fields
//   dbus_*      : data-memory bus (word-aligned address, byte strobes)
//   read_data   : formatted load result for MEM/WB
//   stall       : hold upstream stages while the access is in flight
//   misaligned  : pulse for misaligned / illegal accesses (no bus cycle)
//   bus_err     : timeout pulse, only with LSU_TIMEOUT_EN defined
// Optional feature macro: LSU_TIMEOUT_EN enables the ack timeout counter.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       store_data,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [31:0]       dbus_wdata,
  output logic [3:0]        dbus_wstrb,
  input  logic [31:0]       dbus_rdata,
  input  logic              dbus_ack,
  output logic [31:0]       read_data,
  output logic              stall,
  output logic              misaligned,
  output logic              bus_err
);

  lsu_state_t        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       read_data_q, read_data_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_err_q, bus_err_d;
`else
  logic [31:0]       timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYCLES);
`endif

  logic        access, bad;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [31:0] al_load, al_wdata;
  logic [3:0]  al_wstrb;

  assign access = mem_rd | mem_wr;
  assign bad    = is_misaligned(funct3, mem_addr[1:0], mem_wr);

  // In IDLE the aligner formats the live store operand; afterwards it
  // formats the returning read word with the latched size/offset.
  assign al_f3  = (state_q == IDLE) ? funct3 : f3_q;
  assign al_off = (state_q == IDLE) ? mem_addr[1:0] : off_q;

  lsu_align u_align (
    .funct3    (al_f3),
    .byte_off  (al_off),
    .rdata     (dbus_rdata),
    .sd        (store_data),
    .load_data (al_load),
    .wstrb     (al_wstrb),
    .wdata     (al_wdata)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    read_data_d = read_data_q;
    f3_d        = f3_q;
    off_d       = off_q;
    stall       = 1'b0;
    misaligned  = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
    bus_err_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (access) begin
          if (bad) begin
            misaligned = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = mem_wr;
            addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
            wdata_d = mem_wr ? al_wdata : 32'h0;
            wstrb_d = mem_wr ? al_wstrb : 4'h0;
            f3_d    = funct3;
            off_d   = mem_addr[1:0];
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dbus_ack) begin
          req_d       = 1'b0;
          read_data_d = we_q ? 32'h0 : al_load;
          state_d     = DONE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_d       = 1'b0;
          read_data_d = 32'h0;
          bus_err_d   = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      read_data_q <= 32'h0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      read_data_q <= read_data_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_wdata = wdata_q;
  assign dbus_wstrb = wstrb_q;
  // A rejected access must present zero to MEM/WB without disturbing the held value.
  assign read_data  = misaligned ? 32'h0 : read_data_q;
`ifdef LSU_TIMEOUT_EN
  assign bus_err    = bus_err_q;
`else
  assign bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus randomized
// accesses checked against an arithmetic reference model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic [31:0] mem_addr, store_data;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;
  logic [31:0] read_data;
  logic        stall, misaligned, bus_err;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .funct3(funct3), .mem_addr(mem_addr), .store_data(store_data),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb), .dbus_rdata(dbus_rdata),
    .dbus_ack(dbus_ack), .read_data(read_data), .stall(stall),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [2:0] f3);
    return 1 << (int'(f3) % 4);
  endfunction

  function automatic logic ref_legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    logic known;
    if (wr) known = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    known = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return known && ((a % ref_size(f3)) == 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int unsigned b;
    logic [31:0] v;
    b = a % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = (rd >> (8 * b)) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (rd >> (8 * (b - b % 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << ref_size(f3)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] v;
    int s;
    s = ref_size(f3);
    v = 32'h0;
    for (int i = 0; i < 4; i++) v = v | (((sd >> (8 * (i % s))) & 32'hFF) << (8 * i));
    return v;
  endfunction

  // ---------------- generic access ----------------
  // Entered and left 1 time unit after a rising edge with the unit idle.
  task automatic run_access(input string nm, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rd, input int delay);
    logic [31:0] exp_rd, held;
    logic [2:0]  flags;
    held = read_data;
    mem_rd = !wr; mem_wr = wr; funct3 = f3; mem_addr = a; store_data = sd;
    #3;
    if (!ref_legal(wr, f3, a)) begin
      flags = {stall, dbus_req, misaligned};
      vecs++;
      if (flags !== 3'b001 || read_data !== 32'h0) begin
        errs++;
        $display("FAIL %s reject: stall/req/mis=%b read_data=%h, need 001 and 0", nm, flags, read_data);
      end
      @(posedge clk); #1;
      mem_rd = 0; mem_wr = 0;
      #3;
      vecs++;
      if ({stall, dbus_req, misaligned} !== 3'b000 || read_data !== held) begin
        errs++;
        $display("FAIL %s after-reject: stall/req/mis=%b read_data=%h, need 000 and %h",
                 nm, {stall, dbus_req, misaligned}, read_data, held);
      end
      $display("access %s rejected", nm);
      @(posedge clk); #1;
      return;
    end
    exp_rd = wr ? 32'h0 : ref_load(f3, a, rd);
    vecs++;
    if ({stall, dbus_req, misaligned} !== 3'b100) begin
      errs++;
      $display("FAIL %s detect: stall/req/mis=%b, need 100", nm, {stall, dbus_req, misaligned});
    end
    @(posedge clk); #1;
    for (int w = 0; w <= delay; w++) begin
      if (w == delay) begin dbus_ack = 1; dbus_rdata = rd; end
      #3;
      vecs++;
      if ({stall, dbus_req, dbus_we, bus_err} !== {3'b110 | {2'b00, wr}, 1'b0}) begin
        errs++;
        $display("FAIL %s req cyc %0d: stall/req/we/err=%b, need %b", nm, w,
                 {stall, dbus_req, dbus_we, bus_err}, {2'b11, wr, 1'b0});
      end
      vecs++;
      if (dbus_addr !== (a & ~32'h3) || dbus_wstrb !== (wr ? ref_wstrb(f3, a) : 4'h0)) begin
        errs++;
        $display("FAIL %s addr/strb: %h/%b, need %h/%b", nm, dbus_addr, dbus_wstrb,
                 a & ~32'h3, wr ? ref_wstrb(f3, a) : 4'h0);
      end
      if (wr) begin
        vecs++;
        if (dbus_wdata !== ref_wdata(f3, sd)) begin
          errs++;
          $display("FAIL %s wdata: %h, need %h", nm, dbus_wdata, ref_wdata(f3, sd));
        end
      end
      @(posedge clk); #1;
      dbus_ack = 0; dbus_rdata = $urandom;
    end
    #3;
    vecs++;
    if ({stall, dbus_req} !== 2'b00 || read_data !== exp_rd) begin
      errs++;
      $display("FAIL %s done: stall/req=%b read_data=%h, need 00 and %h", nm,
               {stall, dbus_req}, read_data, exp_rd);
    end
    @(posedge clk); #1;
    mem_rd = 0; mem_wr = 0;
    #3;
    vecs++;
    if ({stall, dbus_req} !== 2'b00 || read_data !== exp_rd) begin
      errs++;
      $display("FAIL %s hold: stall/req=%b read_data=%h, need 00 and %h", nm,
               {stall, dbus_req}, read_data, exp_rd);
    end
    $display("access %s wr=%0d f3=%0d addr=%h delay=%0d read_data=%h", nm, wr, f3, a, delay, read_data);
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 0; mem_rd = 0; mem_wr = 0; funct3 = 0; mem_addr = 0; store_data = 0;
    dbus_ack = 0; dbus_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb, read_data, stall, misaligned, bus_err} !== '0) begin
      errs++;
      $display("FAIL reset outputs: req=%b we=%b addr=%h wdata=%h strb=%b rd=%h, need all 0",
               dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb, read_data);
    end
    reset = 1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_directed();
    run_access("LB_0x103",  1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0);
    run_access("LBU_0x103", 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_1234, 0);
    run_access("SH_0x202",  1'b1, 3'd1, 32'h202, 32'hDEAD_BEEF, 32'h1111_1111, 0);
    run_access("LW_0x305",  1'b0, 3'd2, 32'h305, 32'h0, 32'h0, 0);
    run_access("LHU_0x402", 1'b0, 3'd5, 32'h402, 32'h0, 32'hA5A5_0000, 5);
    run_access("SB_0x3",    1'b1, 3'd0, 32'h3, 32'h0000_00C3, 32'h0, 1);
    run_access("SHU_ill",   1'b1, 3'd5, 32'h10, 32'h1234, 32'h0, 0);
    run_access("F3_7_ill",  1'b0, 3'd7, 32'h20, 32'h0, 32'h0, 0);
  endtask

  task automatic test_reset_in_req();
    mem_rd = 1; mem_wr = 0; funct3 = 3'd2; mem_addr = 32'h600;
    @(posedge clk); #1;
    #3;
    vecs++;
    if (dbus_req !== 1'b1) begin
      errs++;
      $display("FAIL rst_in_req pre: req=%b, need 1", dbus_req);
    end
    reset = 0; mem_rd = 0;
    #1;
    vecs++;
    if ({dbus_req, stall, read_data} !== 34'h0) begin
      errs++;
      $display("FAIL rst_in_req async: req=%b stall=%b rd=%h, need 0", dbus_req, stall, read_data);
    end
    @(posedge clk); #1;
    reset = 1;
    dbus_ack = 1; dbus_rdata = 32'hFFFF_FFFF;
    #3;
    vecs++;
    if ({dbus_req, stall} !== 2'b00) begin
      errs++;
      $display("FAIL rst_in_req late ack: req/stall=%b, need 00", {dbus_req, stall});
    end
    @(posedge clk); #1;
    dbus_ack = 0;
    #3;
    vecs++;
    if ({dbus_req, stall, read_data} !== 34'h0) begin
      errs++;
      $display("FAIL rst_in_req after ack: req=%b stall=%b rd=%h, need 0", dbus_req, stall, read_data);
    end
    $display("reset during REQ checked, read_data=%h", read_data);
    @(posedge clk); #1;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    run_access("LW_prime", 1'b0, 3'd2, 32'h700, 32'h0, 32'h1357_9BDF, 0);
    mem_rd = 1; funct3 = 3'd2; mem_addr = 32'h704;
    @(posedge clk); #1;
    for (int w = 0; w < 16; w++) begin
      #3;
      vecs++;
      if ({dbus_req, bus_err} !== 2'b10) begin
        errs++;
        $display("FAIL timeout wait cyc %0d: req/err=%b, need 10", w, {dbus_req, bus_err});
      end
      @(posedge clk); #1;
    end
    #3;
    vecs++;
    if ({dbus_req, stall, bus_err} !== 3'b001 || read_data !== 32'h0) begin
      errs++;
      $display("FAIL timeout done: req/stall/err=%b rd=%h, need 001 and 0", {dbus_req, stall, bus_err}, read_data);
    end
    @(posedge clk); #1;
    mem_rd = 0;
    #3;
    vecs++;
    if (bus_err !== 1'b0) begin
      errs++;
      $display("FAIL timeout pulse width: err=%b, need 0", bus_err);
    end
    $display("timeout after 16 REQ cycles checked");
    @(posedge clk); #1;
    run_access("LW_ack_cyc16", 1'b0, 3'd2, 32'h708, 32'h0, 32'hCAFE_F00D, 15);
  endtask
`else
  task automatic test_timeout();
    run_access("LW_wait20", 1'b0, 3'd2, 32'h708, 32'h0, 32'hCAFE_F00D, 20);
  endtask
`endif

  task automatic test_random();
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 4095));
      run_access($sformatf("rnd%0d", n), wr, f3, a, $urandom, $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_in_req();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Converts one RV32 load or store into a single req/ack transaction on the data-memory bus.
- Formats load data by byte/halfword extraction and sign/zero extension.
- Stalls the pipeline until the transaction completes.
- Its read_data output feeds the MEM/WB register's read data input.

Parameters:
- ADDR_W, 32: byte-address width of mem_addr input and dbus_addr.
- TIMEOUT_CYCLES, 16: cycles without ack before a bus error is flagged (used only with LSU_TIMEOUT_EN).

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- mem_rd  input  1  current EX/MEM instruction is a load.
- mem_wr  input  1  current EX/MEM instruction is a store. Never high together with mem_rd.
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_addr  input  ADDR_W  byte address (ALU result).
- store_data  input  32  rs2 value for stores.
- dbus_req  output  1  bus request, held until ack.
- dbus_we  output  1  1 = write.
- dbus_addr  output  ADDR_W  word-aligned address, bits [1:0] = 0.
- dbus_wdata  output  32  lane-replicated store data.
- dbus_wstrb  output  4  byte strobes. All 0 on reads.
- dbus_rdata  input  32  read word, valid with ack.
- dbus_ack  input  1  single-cycle completion.
- read_data  output  32  formatted load result, valid in the DONE cycle.
- stall  output  1  hold PC, IF/ID, ID/EX and EX/MEM; insert a bubble into MEM/WB.
- misaligned  output  1  one-cycle pulse on a misaligned or illegal access.
- bus_err  output  1  one-cycle timeout pulse. Tied 0 without LSU_TIMEOUT_EN.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All registered outputs, including dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb, read_data and bus_err, go to 0 immediately.
  - An in-flight transaction is abandoned; a late ack is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Access = mem_rd|mem_wr. An access asserts stall combinationally in the same cycle.
  - Legal access: latch dbus_addr = {mem_addr[ADDR_W-1:2],2'b00}, dbus_we = mem_wr, wstrb and wdata, then go to REQ.
  - Misaligned access: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Illegal funct3: 011, 110, 111, or loads/stores with a U variant (stores with 100/101).
  - Misaligned or illegal: no bus request, misaligned=1 combinationally, stall=0, read_data=0, stay in IDLE. The instruction proceeds.
- REQ:
  - dbus_req=1 and stall=1.
  - On dbus_ack: drop req next cycle and capture formatted dbus_rdata into read_data (loads) or 0 (stores), then go to DONE.
  - Ack in the first REQ cycle is legal.
- DONE:
  - stall=0 for exactly one cycle, so the pipeline advances and MEM/WB captures read_data.
  - Next state is IDLE. read_data holds its value until the next capture.
- Latency:
  - Minimum stall is 2 cycles (IDLE detect + REQ with same-cycle ack), then DONE.
  - Total is 3 cycles per access with zero-wait memory.
- Load formatting, with b = addr[1:0]:
  - B/BU: byte b, sign- or zero-extended.
  - H/HU: halfword addr[1], sign- or zero-extended.
  - W: full word.
- Store formatting:
  - SB: wdata = {4{sd[7:0]}}, wstrb = 0001<<b.
  - SH: wdata = {2{sd[15:0]}}, wstrb = 0011<<b.
  - SW: wdata = sd, wstrb = 1111.
- dbus_ack outside REQ is ignored.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on REQ entry and increments each REQ cycle without ack.
  - At count == TIMEOUT_CYCLES-1 with no ack: drop dbus_req, pulse bus_err for one cycle, set read_data=0, go to DONE.
  - Ack in that same cycle wins; no bus_err.
- Undefined: REQ waits indefinitely, there is no counter, and bus_err=0.

Decomposition:
- Package lsu_pkg holds:
  - enum lsu_state_t {IDLE, REQ, DONE}
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU
  - function is_misaligned(funct3, addr[1:0], is_store)
- Sub-module lsu_align, purely combinational, produces:
  - load extract/extend from (funct3, b, rdata)
  - store wstrb/wdata from (funct3, b, sd)
- mem_lsu keeps the FSM, latches and optional timeout counter.

Test Plan:
- LB from addr 0x103, rdata 0x80FF_1234, zero-wait ack: stall high for 2 cycles, dbus_addr 0x100, DONE read_data 0xFFFF_FF80. LBU gives 0x0000_0080.
- SH at 0x202 with sd 0xDEAD_BEEF: dbus_we=1, wstrb 1100, wdata 0xBEEF_BEEF, read_data 0.
- LW at 0x305: misaligned pulses for 1 cycle, no dbus_req, stall 0, read_data 0.
- LHU at 0x402 with ack delayed 5 cycles, rdata 0xA5A5_0000: stall 7 cycles, read_data 0x0000_A5A5.
- Assert reset low while in REQ, then send ack after release: req drops immediately, state is IDLE, the ack is ignored and read_data stays 0.
- Under LSU_TIMEOUT_EN with no ack: bus_err pulses after 16 REQ cycles, DONE follows with read_data 0. Ack in cycle 16 instead gives no bus_err.
